// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Counter wide enough to hold 0..maxburst inclusive.
  function automatic int cnt_width(input int maxburst);
    return $clog2(maxburst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundles the requester handshakes and the FIFO write-port signals.
// Latency: n/a (wiring only).
// Backpressure: req_ready and wfull carry the stall information.
// master: arbiter side (consumes requests and wfull, drives ready/winc/wdata/grant/busy).
// slave : producers + FIFO write-pointer side.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  modport master (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, grant, busy
  );

  modport slave (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req_i at or after start_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; any_o low when no request is pending.
// Ports: req_i request vector, start_i highest-priority index,
//        gnt_o one-hot winner, idx_o winner index, any_o some request set.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] start_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);
  localparam int IW = $clog2(NREQ);

  // Walk from lowest priority to highest so the last hit (offset 0) wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(start_i) + k) % NREQ]) begin
        gnt_o = '0;
        gnt_o[(int'(start_i) + k) % NREQ] = 1'b1;
        idx_o = IW'((int'(start_i) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one async-FIFO write port among NREQ producers, round-robin, bursts up to MAXBURST.
// Latency: grant 1 cycle after valid in IDLE; one IDLE cycle between bursts.
// Backpressure: wfull stalls the owner (ready/winc low) without ending the burst.
// Ports: wclk/wrst (sync active-high), bus = fifo_wr_arbiter_if.master.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input logic               wclk,
  input logic               wrst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(MAXBURST);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            own_vld;
  logic            own_last;
  logic            xfer;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (bus.req_valid),
    .start_i(rr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign own_vld  = bus.req_valid[owner_q];
  assign own_last = bus.req_last[owner_q];
  // wfull is registered and already accounts for last cycle's write.
  assign xfer     = (state_q == BURST) && own_vld && !bus.wfull;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.winc      = 1'b0;
    bus.wdata     = bus.req_data[int'(owner_q)*DSIZE +: DSIZE];
    bus.grant     = grant_q;
    bus.busy      = (state_q == BURST);

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_gnt;
          owner_d = pick_idx;
          cnt_d   = '0;
          rr_d    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      BURST: begin
        // Reset kills the in-flight word: nothing is written or acknowledged.
        bus.req_ready[owner_q] = !bus.wfull && !wrst;
        bus.winc               = xfer && !wrst;
        if (!own_vld) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (own_last || (cnt_q + CW'(1) == CW'(MAXBURST))) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
endmodule
